tick_timer_bank: RTL
====================

Name: tick_timer_bank

Overview:
Parametrised bank of independent programmable tick timers for the LED display module. It generalises the single-channel time_mode divider to CHANNELS timers of WIDTH bits each. Each channel has a latched period, a periodic or one-shot mode, and a busy/count readback. Its single-cycle fc pulses drive display refresh, digit scan and blink timing.

Parameters:
WIDTH, 27, bit width of each channel's period and counter
CHANNELS, 4, number of independent timer channels
PRESCALE, 50, shared prescaler divide ratio (≥1); used only when TIMER_PRESCALE_EN is defined

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
tm_value  input  CHANNELS*WIDTH  period per channel; channel i = bits [i*WIDTH +: WIDTH]; sampled only on load
load  input  CHANNELS  per-channel latch of period/mode plus restart
oneshot  input  CHANNELS  mode sampled on load; 1 = one-shot, 0 = periodic
count_en  input  CHANNELS  per-channel count enable
fc  output  CHANNELS  registered single-cycle terminal pulse per channel
busy  output  CHANNELS  channel running (loaded, period ≠ 0, not expired)
count  output  CHANNELS*WIDTH  current counter value per channel, same slicing as tm_value

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, and is the only reset.
- Reset values: all per-channel period registers P=0, counters cnt=0, mode=periodic, running=0, fc=0, busy=0, count=0. With the macro, the prescaler is also 0.
- Channel independence: channels share no state except the optional prescaler.
- Priority per channel, each edge: rst > load > count step > hold.
- Load (load[i]=1 at edge):
  - P<=tm_value slice, mode<=oneshot[i], cnt<=0, fc[i]<=0.
  - running<=(tm_value slice ≠ 0).
  - count_en[i] is ignored on that edge.
- Count step (running, count_en[i]=1, step tick):
  - If cnt==P-1: cnt<=0 and fc[i]<=1. In one-shot mode, running<=0 on the same edge.
  - Otherwise: cnt<=cnt+1 and fc[i]<=0.
- Hold (not running, or count_en[i]=0): cnt unchanged, fc[i]<=0.
- Latency: the first fc rises P enabled step edges after the load edge. Periodic mode then repeats every P enabled steps; fc is never wider than one cycle unless P=1.
- P=1: periodic mode gives fc high on every enabled step. One-shot mode gives one pulse.
- P=0: the channel is idle, busy=0, no fc, cnt held at 0.
- busy = running, registered. In one-shot mode busy falls on the same edge fc rises.
- One-shot restart: an expired one-shot channel stays at cnt=0, busy=0 until the next load.
- tm_value changes without load: no effect on the channel.
- Reload mid-count: restarts immediately from 0 with the new P. A pending terminal on that same edge is discarded, so no fc.
- rst mid-operation: all state clears at the next edge, regardless of load or count_en.
- Arithmetic: unsigned, compare against P-1 in WIDTH bits. cnt never exceeds P-1, so no wrap beyond the period.

Optional Feature:
TIMER_PRESCALE_EN
- Defined:
  - A shared free-running prescaler counts 0..PRESCALE-1 from reset and generates step tick = (prescaler==PRESCALE-1).
  - Channel count steps occur only on edges where count_en[i] and tick are both high; fc is still one clk wide.
  - load does not reset the prescaler, so first-pulse latency after load is P*PRESCALE minus prescaler phase.
  - PRESCALE=1 gives a tick every cycle.
- Undefined: step tick is constant 1, so channels advance on every enabled clk edge. The prescaler logic and PRESCALE are unused.

Test Plan:
1. Reset: rst=1 for 5 cycles with load=4'hF and count_en=4'hF driven -> fc=0, busy=0, count=0 throughout and on the first cycle after release.
2. Periodic, ch0: load P=20, oneshot=0, count_en=1 -> first fc exactly 20 cycles after the load edge, then every 20 cycles for 5 periods. count runs 0..19 and wraps; busy stays 1.
3. One-shot, ch1: load P=5, oneshot=1 -> single fc 5 cycles after load; busy falls on the same edge. No fc and count=0 for the following 50 cycles. A reload with P=5 produces a fresh pulse after 5 cycles.
4. Enable gating, ch2: P=10, drop count_en at count=4 for 7 cycles -> count holds 4 and fc is delayed by exactly 7 cycles (17 cycles after load). Other channels are unaffected.
5. Edge periods, ch3:
   - load P=0 -> busy=0, no fc over 30 cycles.
   - load P=1 periodic -> fc=1 every enabled cycle.
   - P=1 one-shot -> exactly one fc.
6. Reload and mid-op reset:
   - ch0 at count=12 of P=20, load P=3 -> count=0, fc 3 cycles later.
   - Load coinciding with cnt==P-1 -> no fc that edge.
   - rst during activity -> all outputs 0 next edge.
   - With TIMER_PRESCALE_EN and PRESCALE=4, P=5 -> fc period 20 clk.

Source files
------------

// File: rtl/tick_timer_bank.sv
// tick_timer_bank: CHANNELS independent WIDTH-bit tick timers with periodic or one-shot modes.
// Define TIMER_PRESCALE_EN to pace all channels from a shared PRESCALE divider.
module tick_timer_bank #(
    parameter int unsigned WIDTH    = 27,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PRESCALE = 50
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*WIDTH-1:0]    tm_value,
    input  logic [CHANNELS-1:0]          load,
    input  logic [CHANNELS-1:0]          oneshot,
    input  logic [CHANNELS-1:0]          count_en,
    output logic [CHANNELS-1:0]          fc,
    output logic [CHANNELS-1:0]          busy,
    output logic [CHANNELS*WIDTH-1:0]    count
);

    logic stepTick;

`ifdef TIMER_PRESCALE_EN
    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

    logic [PreW-1:0] prescaleQ, prescaleD;

    // Free-running divider; loads never touch it, so channels see a common tick phase.
    always_comb begin
        prescaleD = (prescaleQ == PreLast) ? '0 : prescaleQ + PreW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaleQ <= '0;
        end else begin
            prescaleQ <= prescaleD;
        end
    end

    assign stepTick = (prescaleQ == PreLast);
`else
    logic unusedPrescale;
    assign unusedPrescale = ^PRESCALE;
    assign stepTick       = 1'b1;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : gChannel
        logic [WIDTH-1:0] periodQ, periodD;
        logic [WIDTH-1:0] cntQ, cntD;
        logic             oneshotQ, oneshotD;
        logic             runQ, runD;
        logic             fcQ, fcD;
        logic [WIDTH-1:0] tmSlice;
        logic             terminal;

        assign tmSlice  = tm_value[i*WIDTH +: WIDTH];
        assign terminal = (cntQ == periodQ - WIDTH'(1));

        // Load wins over a step, so a terminal count coinciding with a reload never pulses.
        always_comb begin
            periodD  = periodQ;
            oneshotD = oneshotQ;
            cntD     = cntQ;
            runD     = runQ;
            fcD      = 1'b0;
            if (load[i]) begin
                periodD  = tmSlice;
                oneshotD = oneshot[i];
                cntD     = '0;
                runD     = (tmSlice != '0);
            end else if (runQ && count_en[i] && stepTick) begin
                if (terminal) begin
                    cntD = '0;
                    fcD  = 1'b1;
                    if (oneshotQ) begin
                        runD = 1'b0;
                    end
                end else begin
                    cntD = cntQ + WIDTH'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                periodQ  <= '0;
                oneshotQ <= 1'b0;
                cntQ     <= '0;
                runQ     <= 1'b0;
                fcQ      <= 1'b0;
            end else begin
                periodQ  <= periodD;
                oneshotQ <= oneshotD;
                cntQ     <= cntD;
                runQ     <= runD;
                fcQ      <= fcD;
            end
        end

        assign count[i*WIDTH +: WIDTH] = cntQ;
        assign fc[i]                   = fcQ;
        assign busy[i]                 = runQ;
    end

endmodule
